// File: rtl/enemy_bullet.sv
// Single enemy projectile: frame-counted cooldown, spawn under the selected shooter,
// per-frame fall with player-hit / off-screen checks. Optional player-bullet cancel via ENEMY_BULLET_CANCEL_EN.
module enemy_bullet #(
  parameter logic [9:0]  delay_frames_p = 10'd300,
  parameter logic [9:0]  step_p         = 10'd4,
  parameter logic [9:0]  bullet_w_p     = 10'd2,
  parameter logic [9:0]  bullet_h_p     = 10'd8,
  parameter logic [9:0]  screen_bot_p   = 10'd479,
  parameter logic [11:0] color_p        = {4'hF, 4'h0, 4'h0}
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       frame_i,
  input  logic       enable_i,
  input  logic       shooter_valid_i,
  input  logic [9:0] shooter_left_i,
  input  logic [9:0] shooter_right_i,
  input  logic [9:0] shooter_bot_i,
  input  logic [9:0] player_left_i,
  input  logic [9:0] player_right_i,
  input  logic [9:0] player_top_i,
  input  logic [9:0] player_bot_i,
  input  logic       pbullet_valid_i,
  input  logic [9:0] pbullet_left_i,
  input  logic [9:0] pbullet_right_i,
  input  logic [9:0] pbullet_top_i,
  input  logic [9:0] pbullet_bot_i,
  output logic       active_o,
  output logic [9:0] left_pos_o,
  output logic [9:0] right_pos_o,
  output logic [9:0] top_pos_o,
  output logic [9:0] bot_pos_o,
  output logic       fire_o,
  output logic       player_hit_o,
  output logic       cancel_o,
  output logic [3:0] bullet_red_o,
  output logic [3:0] bullet_green_o,
  output logic [3:0] bullet_blue_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_FALLING  = 2'd2
  } state_e;

  localparam logic [9:0] last_cnt_lc = delay_frames_p - 10'd1;

  state_e     state_q, state_d;
  logic [9:0] count_q, count_d;
  logic       active_q, active_d;
  logic [9:0] left_q, left_d, right_q, right_d, top_q, top_d, bot_q, bot_d;
  logic       fire_q, fire_d, hit_q, hit_d, cancel_q, cancel_d;

  logic [9:0]  spawn_mid, spawn_left, spawn_top;
  logic [10:0] cand_top, cand_bot, cur_left, cur_right;
  logic        player_ovl, pbullet_ovl;
  logic        clear_bullet, restart;

  // Midpoint uses the full 11-bit sum so wide shooters near the right edge do not wrap.
  assign spawn_mid  = 10'(({1'b0, shooter_left_i} + {1'b0, shooter_right_i}) >> 1);
  assign spawn_left = spawn_mid - (bullet_w_p >> 1);
  assign spawn_top  = shooter_bot_i + 10'd1;

  assign cur_left  = {1'b0, left_q};
  assign cur_right = {1'b0, right_q};
  assign cand_top  = {1'b0, top_q} + {1'b0, step_p};
  assign cand_bot  = cand_top + {1'b0, bullet_h_p} - 11'd1;

  assign player_ovl = (cur_left <= {1'b0, player_right_i}) && (cur_right >= {1'b0, player_left_i}) &&
                      (cand_top <= {1'b0, player_bot_i})   && (cand_bot >= {1'b0, player_top_i});

`ifdef ENEMY_BULLET_CANCEL_EN
  assign pbullet_ovl = pbullet_valid_i &&
                       (cur_left <= {1'b0, pbullet_right_i}) && (cur_right >= {1'b0, pbullet_left_i}) &&
                       (cand_top <= {1'b0, pbullet_bot_i})   && (cand_bot >= {1'b0, pbullet_top_i});
`else
  logic unused_pbullet;
  assign unused_pbullet = ^{pbullet_valid_i, pbullet_left_i, pbullet_right_i, pbullet_top_i, pbullet_bot_i};
  assign pbullet_ovl    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    active_d     = active_q;
    left_d       = left_q;
    right_d      = right_q;
    top_d        = top_q;
    bot_d        = bot_q;
    fire_d       = 1'b0;
    hit_d        = 1'b0;
    cancel_d     = 1'b0;
    clear_bullet = 1'b0;
    restart      = 1'b0;

    if (!enable_i) begin
      state_d      = ST_IDLE;
      count_d      = 10'd0;
      clear_bullet = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_COOLDOWN;
          count_d      = 10'd0;
          clear_bullet = 1'b1;
        end
        ST_COOLDOWN: begin
          if (frame_i) begin
            if (count_q != last_cnt_lc) begin
              count_d = count_q + 10'd1;
            end else if (shooter_valid_i) begin
              state_d  = ST_FALLING;
              active_d = 1'b1;
              fire_d   = 1'b1;
              left_d   = spawn_left;
              right_d  = spawn_left + bullet_w_p - 10'd1;
              top_d    = spawn_top;
              bot_d    = spawn_top + bullet_h_p - 10'd1;
            end
          end
        end
        ST_FALLING: begin
          // Priority: player hit, then cancel, then off-screen.
          if (frame_i) begin
            if (player_ovl) begin
              hit_d   = 1'b1;
              restart = 1'b1;
            end else if (pbullet_ovl) begin
              cancel_d = 1'b1;
              restart  = 1'b1;
            end else if (cand_top > {1'b0, screen_bot_p}) begin
              restart = 1'b1;
            end else begin
              top_d = cand_top[9:0];
              bot_d = cand_bot[9:0];
            end
          end
        end
        default: begin
          state_d      = ST_IDLE;
          clear_bullet = 1'b1;
        end
      endcase
    end

    if (restart) begin
      state_d      = ST_COOLDOWN;
      count_d      = 10'd0;
      clear_bullet = 1'b1;
    end
    if (clear_bullet) begin
      active_d = 1'b0;
      left_d   = 10'd0;
      right_d  = 10'd0;
      top_d    = 10'd0;
      bot_d    = 10'd0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      count_q  <= 10'd0;
      active_q <= 1'b0;
      left_q   <= 10'd0;
      right_q  <= 10'd0;
      top_q    <= 10'd0;
      bot_q    <= 10'd0;
      fire_q   <= 1'b0;
      hit_q    <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      active_q <= active_d;
      left_q   <= left_d;
      right_q  <= right_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      fire_q   <= fire_d;
      hit_q    <= hit_d;
      cancel_q <= cancel_d;
    end
  end

  assign active_o       = active_q;
  assign left_pos_o     = left_q;
  assign right_pos_o    = right_q;
  assign top_pos_o      = top_q;
  assign bot_pos_o      = bot_q;
  assign fire_o         = fire_q;
  assign player_hit_o   = hit_q;
  assign cancel_o       = cancel_q;
  assign bullet_red_o   = color_p[11:8];
  assign bullet_green_o = color_p[7:4];
  assign bullet_blue_o  = color_p[3:0];

endmodule

// File: tb/tb_enemy_bullet.sv
// Directed + randomized bench for enemy_bullet (delay 3 frames, step 4) against a frame-level reference model.
module tb_enemy_bullet;

  localparam int D = 3, S = 4, W = 2, H = 8, BOT = 479;
`ifdef ENEMY_BULLET_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_ni, frame_i, enable_i, shooter_valid_i, pbullet_valid_i;
  logic [9:0] shooter_left_i, shooter_right_i, shooter_bot_i;
  logic [9:0] player_left_i, player_right_i, player_top_i, player_bot_i;
  logic [9:0] pbullet_left_i, pbullet_right_i, pbullet_top_i, pbullet_bot_i;
  logic       active_o, fire_o, player_hit_o, cancel_o;
  logic [9:0] left_pos_o, right_pos_o, top_pos_o, bot_pos_o;
  logic [3:0] bullet_red_o, bullet_green_o, bullet_blue_o;

  enemy_bullet #(.delay_frames_p(10'd3), .step_p(10'd4)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .frame_i(frame_i), .enable_i(enable_i),
    .shooter_valid_i(shooter_valid_i), .shooter_left_i(shooter_left_i),
    .shooter_right_i(shooter_right_i), .shooter_bot_i(shooter_bot_i),
    .player_left_i(player_left_i), .player_right_i(player_right_i),
    .player_top_i(player_top_i), .player_bot_i(player_bot_i),
    .pbullet_valid_i(pbullet_valid_i), .pbullet_left_i(pbullet_left_i),
    .pbullet_right_i(pbullet_right_i), .pbullet_top_i(pbullet_top_i),
    .pbullet_bot_i(pbullet_bot_i),
    .active_o(active_o), .left_pos_o(left_pos_o), .right_pos_o(right_pos_o),
    .top_pos_o(top_pos_o), .bot_pos_o(bot_pos_o), .fire_o(fire_o),
    .player_hit_o(player_hit_o), .cancel_o(cancel_o),
    .bullet_red_o(bullet_red_o), .bullet_green_o(bullet_green_o), .bullet_blue_o(bullet_blue_o)
  );

  // reference model: game-level view of the bullet
  bit m_running;   // enabled and past the first enabled cycle
  bit m_flying;
  int m_waited;    // frames seen since the cooldown began
  int m_l, m_r, m_t, m_b;
  bit m_fire, m_hit, m_cancel;

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;

  function automatic bit boxes_touch(int al, int ar, int at, int ab, int bl, int br, int bt, int bb);
    return (al <= br) && (ar >= bl) && (at <= bb) && (ab >= bt);
  endfunction

  task automatic m_drop_bullet();
    m_flying = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_waited = 0;
  endtask

  task automatic m_reset();
    m_running = 0; m_drop_bullet();
    m_fire = 0; m_hit = 0; m_cancel = 0;
  endtask

  task automatic model_step();
    int nt, nb;
    m_fire = 0; m_hit = 0; m_cancel = 0;
    if (!reset_ni) begin
      m_reset();
    end else if (!enable_i) begin
      m_running = 0; m_drop_bullet();
    end else if (!m_running) begin
      m_running = 1; m_drop_bullet();
    end else if (frame_i && !m_flying) begin
      if (m_waited >= D - 1 && shooter_valid_i) begin
        m_l = (int'(shooter_left_i) + int'(shooter_right_i)) / 2 - W / 2;
        m_r = m_l + W - 1;
        m_t = int'(shooter_bot_i) + 1;
        m_b = m_t + H - 1;
        m_flying = 1; m_fire = 1;
      end else begin
        m_waited++;
      end
    end else if (frame_i && m_flying) begin
      nt = m_t + S; nb = nt + H - 1;
      if (boxes_touch(m_l, m_r, nt, nb, player_left_i, player_right_i, player_top_i, player_bot_i)) begin
        m_hit = 1; m_drop_bullet();
      end else if (CANCEL_EN && pbullet_valid_i &&
                   boxes_touch(m_l, m_r, nt, nb, pbullet_left_i, pbullet_right_i, pbullet_top_i, pbullet_bot_i)) begin
        m_cancel = 1; m_drop_bullet();
      end else if (nt > BOT) begin
        m_drop_bullet();
      end else begin
        m_t = nt; m_b = nb;
      end
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [15:0] obs, input int exp);
    chk_cnt++;
    assert (obs === 16'(exp)) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("active", active_o, int'(m_flying));
    chk("left", left_pos_o, m_l);
    chk("right", right_pos_o, m_r);
    chk("top", top_pos_o, m_t);
    chk("bot", bot_pos_o, m_b);
    chk("fire", fire_o, int'(m_fire));
    chk("hit", player_hit_o, int'(m_hit));
    chk("cancel", cancel_o, int'(m_cancel));
  endtask

  // drivers
  task automatic cyc(input bit f);
    frame_i = f;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    frame_i = 1'b0;
  endtask

  task automatic frame();
    cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic set_shooter(input int l, input int r, input int b);
    shooter_left_i = 10'(l); shooter_right_i = 10'(r); shooter_bot_i = 10'(b);
  endtask

  task automatic set_player(input int l, input int r, input int t, input int b);
    player_left_i = 10'(l); player_right_i = 10'(r); player_top_i = 10'(t); player_bot_i = 10'(b);
  endtask

  task automatic set_pbullet(input bit v, input int l, input int r, input int t, input int b);
    pbullet_valid_i = v;
    pbullet_left_i = 10'(l); pbullet_right_i = 10'(r); pbullet_top_i = 10'(t); pbullet_bot_i = 10'(b);
  endtask

  task automatic spawn_after_cooldown();
    frame(); chk("no_fire_1", fire_o, 0);
    frame(); chk("no_fire_2", fire_o, 0);
    frame(); chk("fire_3", fire_o, 1);
  endtask

  initial begin
    int pl, pt, sl;
    reset_ni = 1'b0; frame_i = 1'b0; enable_i = 1'b1; shooter_valid_i = 1'b1;
    set_shooter(100, 140, 50);
    set_player(300, 340, 440, 460);
    set_pbullet(1'b0, 0, 0, 0, 0);
    m_reset();

    // reset state
    cyc(1'b0); cyc(1'b1);
    chk("rst_active", active_o, 0);
    chk("rst_top", top_pos_o, 0);
    chk("rst_fire", fire_o, 0);
    chk("red", bullet_red_o, 15);
    chk("green", bullet_green_o, 0);
    chk("blue", bullet_blue_o, 0);
    reset_ni = 1'b1;

    // reset and enable: fire on the 3rd frame
    cyc(1'b0);
    spawn_after_cooldown();
    chk("spawn_left", left_pos_o, 119);
    chk("spawn_top", top_pos_o, 51);
    chk("spawn_right", right_pos_o, 120);
    chk("spawn_bot", bot_pos_o, 58);
    chk("spawn_active", active_o, 1);

    // fall into the player box
    set_player(110, 150, 80, 95);
    for (int k = 1; k <= 5; k++) begin
      frame();
      chk("fall_top", top_pos_o, 51 + 4 * k);
      chk("fall_nohit", player_hit_o, 0);
    end
    frame();
    chk("hit_pulse", player_hit_o, 1);
    chk("hit_clear", active_o, 0);
    cyc(1'b0);
    chk("hit_one_cycle", player_hit_o, 0);

    // delayed shooter: fire only once valid rises on frame 6
    set_player(300, 340, 440, 460);
    set_shooter(100, 140, 47);
    shooter_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      frame();
      chk("delay_nofire", fire_o, 0);
    end
    shooter_valid_i = 1'b1;
    frame();
    chk("delay_fire", fire_o, 1);
    chk("delay_top", top_pos_o, 48);

    // off-screen: 48 + 4*107 = 476, next candidate 480 clears silently
    for (int k = 0; k < 107; k++) frame();
    chk("edge_top", top_pos_o, 476);
    chk("edge_active", active_o, 1);
    frame();
    chk("off_active", active_o, 0);
    chk("off_hit", player_hit_o, 0);
    chk("off_cancel", cancel_o, 0);

    // player-bullet overlap on the next candidate
    set_shooter(100, 140, 50);
    spawn_after_cooldown();
    set_pbullet(1'b1, 110, 130, 55, 70);
    frame();
    chk("cancel_pulse", cancel_o, CANCEL_EN ? 1 : 0);
    chk("cancel_nohit", player_hit_o, 0);
    chk("cancel_active", active_o, CANCEL_EN ? 0 : 1);
    chk("cancel_top", top_pos_o, CANCEL_EN ? 0 : 55);

    // fresh start, then player and player bullet both overlapping
    set_pbullet(1'b0, 0, 0, 0, 0);
    enable_i = 1'b0;
    cyc(1'b0);
    chk("dis_active", active_o, 0);
    enable_i = 1'b1;
    cyc(1'b0);
    spawn_after_cooldown();
    set_player(110, 150, 55, 70);
    set_pbullet(1'b1, 110, 130, 55, 70);
    frame();
    chk("both_hit", player_hit_o, 1);
    chk("both_cancel", cancel_o, 0);

    // abort by enable drop mid-fall
    set_player(300, 340, 440, 460);
    set_pbullet(1'b0, 0, 0, 0, 0);
    spawn_after_cooldown();
    frame();
    chk("abort_pre_top", top_pos_o, 55);
    enable_i = 1'b0;
    cyc(1'b0);
    chk("abort_active", active_o, 0);
    chk("abort_top", top_pos_o, 0);
    enable_i = 1'b1;
    cyc(1'b0);
    spawn_after_cooldown();
    frame();

    // asynchronous reset mid-fall: outputs clear before any edge
    #2 reset_ni = 1'b0;
    #1 m_reset();
    chk("async_active", active_o, 0);
    chk("async_top", top_pos_o, 0);
    chk("async_left", left_pos_o, 0);
    cyc(1'b0);
    reset_ni = 1'b1;
    cyc(1'b0);

    // randomized play
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        sl = $urandom_range(10, 800);
        set_shooter(sl, sl + $urandom_range(0, 150), $urandom_range(0, 400));
        pl = $urandom_range(0, 600);
        pt = $urandom_range(0, 450);
        set_player(pl, pl + $urandom_range(0, 200), pt, pt + $urandom_range(0, 60));
        pl = $urandom_range(0, 800);
        pt = $urandom_range(0, 470);
        set_pbullet($urandom_range(0, 3) == 0, pl, pl + $urandom_range(0, 20), pt, pt + $urandom_range(0, 20));
      end
      shooter_valid_i = ($urandom_range(0, 3) != 0);
      enable_i = ($urandom_range(0, 49) != 0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc(1'b0);
      cyc(1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
